// File: rtl/handshake_t_arb_if.sv
// Bundle of the requester-side and transmitter-side signals of the
// handshake_t_arb arbiter. The master modport is the arbiter's view; the
// slave modport is the view of the requesters plus transmitter.
interface handshake_t_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    i_req;
  logic [NREQ*DW-1:0] i_req_data;
  logic [NREQ-1:0]    o_gnt;
  logic [NREQ-1:0]    o_done;
  logic [NREQ-1:0]    o_abort;
  logic [DW-1:0]      o_t_data;
  logic               o_data_avail;
  logic               i_t_rdy;
  logic               o_busy;

  modport master (
    input  i_req, i_req_data, i_t_rdy,
    output o_gnt, o_done, o_abort, o_t_data, o_data_avail, o_busy
  );

  modport slave (
    output i_req, i_req_data, i_t_rdy,
    input  o_gnt, o_done, o_abort, o_t_data, o_data_avail, o_busy
  );
endinterface

// File: rtl/handshake_t_arb.sv
// handshake_t_arb: round-robin arbiter and sequencer in front of one
// four-phase transmit handshake channel. A winner's word is latched and
// presented with data-available; the channel is granted again only after
// the transmitter's ready flag has gone through a full rise/fall cycle.
// Optional transfer timeout: define HS_ARB_TIMEOUT_EN (adds parameter TO_W,
// aborts a transfer after 2^TO_W-1 cycles in LAUNCH/WAIT_DONE).
module handshake_t_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 32
`ifdef HS_ARB_TIMEOUT_EN
  ,
  parameter int TO_W = 8
`endif
) (
  input  logic                i_tclk,
  input  logic                i_trst,
  handshake_t_arb_if.master   io_hs
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_ARB       = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [DW-1:0]   r_t_data;
  logic            r_data_avail;

  logic [DW-1:0]   w_req_word [NREQ];
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_winner;
  logic            w_found;
  logic            w_to_hit;

  // Split the flat request-data bus into one word per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_req_word[gi] = io_hs.i_req_data[gi*DW +: DW];
    end
  endgenerate

  // Round-robin search: first requester above the last winner, wrapping.
  always_comb begin
    w_idx    = r_ptr;
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && io_hs.i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic [NREQ-1:0] r_abort;

  // The counter reaches all-ones on the same edge that aborts the transfer.
  assign w_to_hit = (r_to_cnt == {{(TO_W-1){1'b1}}, 1'b0});

  // Transfer-age counter: held at zero in ARB/DONE, counts while in flight.
  always_ff @(posedge i_tclk or negedge i_trst) begin
    if (!i_trst) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_LAUNCH || r_state == ST_WAIT_DONE) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Abort pulse for the in-flight requester when the counter expires.
  always_ff @(posedge i_tclk or negedge i_trst) begin
    if (!i_trst) begin
      r_abort <= '0;
    end else if ((r_state == ST_LAUNCH || r_state == ST_WAIT_DONE) && w_to_hit) begin
      r_abort <= NREQ'(1) << r_ptr;
    end else begin
      r_abort <= '0;
    end
  end

  assign io_hs.o_abort = r_abort;
`else
  assign w_to_hit      = 1'b0;
  assign io_hs.o_abort = '0;
`endif

  // Main sequencer: arbitrate, launch, follow ready high then low, report.
  always_ff @(posedge i_tclk or negedge i_trst) begin
    if (!i_trst) begin
      r_state      <= ST_ARB;
      r_ptr        <= PW'(NREQ - 1);
      r_gnt        <= '0;
      r_done       <= '0;
      r_t_data     <= '0;
      r_data_avail <= 1'b0;
    end else begin
      r_done <= '0;
      if ((r_state == ST_LAUNCH || r_state == ST_WAIT_DONE) && w_to_hit) begin
        // Timed out: drop the channel, no done pulse, pointer stays advanced.
        r_state      <= ST_ARB;
        r_gnt        <= '0;
        r_t_data     <= '0;
        r_data_avail <= 1'b0;
      end else begin
        case (r_state)
          ST_ARB: begin
            // A high ready flag here belongs to a stale transfer; hold off.
            if (w_found && !io_hs.i_t_rdy) begin
              r_state      <= ST_LAUNCH;
              r_gnt        <= NREQ'(1) << w_winner;
              r_t_data     <= w_req_word[w_winner];
              r_data_avail <= 1'b1;
              r_ptr        <= w_winner;
            end
          end
          ST_LAUNCH: begin
            if (io_hs.i_t_rdy) begin
              r_state      <= ST_WAIT_DONE;
              r_data_avail <= 1'b0;
            end
          end
          ST_WAIT_DONE: begin
            if (!io_hs.i_t_rdy) begin
              r_state <= ST_DONE;
              r_done  <= NREQ'(1) << r_ptr;
            end
          end
          default: begin
            r_state  <= ST_ARB;
            r_gnt    <= '0;
            r_t_data <= '0;
          end
        endcase
      end
    end
  end

  assign io_hs.o_gnt        = r_gnt;
  assign io_hs.o_done       = r_done;
  assign io_hs.o_t_data     = r_t_data;
  assign io_hs.o_data_avail = r_data_avail;
  assign io_hs.o_busy       = (r_state != ST_ARB);

endmodule

// File: tb/tb_handshake_t_arb.sv
// Testbench for handshake_t_arb: table of single transfers (with optional
// reset before and stale-ready lead-in), a scoreboard of expected done
// pulses, and hand-written reset-in-flight and timeout sequences.
module tb_handshake_t_arb;
  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic tclk;
  logic trst_n;
  int   total = 0;
  int   bad   = 0;
  bit   abort_ok = 0;

  handshake_t_arb_if #(.NREQ(NREQ), .DW(DW)) hs ();

`ifdef HS_ARB_TIMEOUT_EN
  handshake_t_arb #(.NREQ(NREQ), .DW(DW), .TO_W(4)) dut (
    .i_tclk (tclk),
    .i_trst (trst_n),
    .io_hs  (hs)
  );
`else
  handshake_t_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .i_tclk (tclk),
    .i_trst (trst_n),
    .io_hs  (hs)
  );
`endif

  initial tclk = 1'b0;
  always #5 tclk = ~tclk;

  typedef struct {
    bit              rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_after;
    logic [NREQ-1:0] exp_gnt;
    int              rise;
    int              fall;
    int              stale;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   data;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge tclk);
    #1;
  endtask

  function automatic logic [DW-1:0] word_of(input int e, input int k);
    return 32'hA5A5_0000 | (32'(e) << 8) | 32'(k);
  endfunction

  task automatic load_words(input int e);
    for (int k = 0; k < NREQ; k++) hs.i_req_data[k*DW +: DW] = word_of(e, k);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_gnt"},   64'(hs.o_gnt), 64'd0);
    chk({name, "_done"},  64'(hs.o_done), 64'd0);
    chk({name, "_abort"}, 64'(hs.o_abort), 64'd0);
    chk({name, "_avail"}, 64'(hs.o_data_avail), 64'd0);
    chk({name, "_data"},  64'(hs.o_t_data), 64'd0);
    chk({name, "_busy"},  64'(hs.o_busy), 64'd0);
  endtask

  task automatic do_reset();
    trst_n       = 1'b0;
    hs.i_req     = '0;
    hs.i_t_rdy   = 1'b0;
    #1;
    chk_idle("reset");
    @(posedge tclk);
    @(posedge tclk);
    #1;
    trst_n = 1'b1;
  endtask

  task automatic xfer(input vec_t v, input int e);
    logic [DW-1:0] exp_word;
    int w;
    if (v.rst) do_reset();
    load_words(e);
    w = 0;
    for (int k = 0; k < NREQ; k++) if (v.exp_gnt[k]) w = k;
    exp_word = word_of(e, w);
    if (v.stale > 0) begin
      hs.i_t_rdy = 1'b1;
      hs.i_req   = v.req;
      repeat (v.stale) begin
        step();
        chk("stale_gnt", 64'(hs.o_gnt), 64'd0);
        chk("stale_busy", 64'(hs.o_busy), 64'd0);
      end
      hs.i_t_rdy = 1'b0;
    end
    hs.i_req = v.req;
    sb_q.push_back('{gnt: v.exp_gnt, data: exp_word});
    step();
    chk("grant", 64'(hs.o_gnt), 64'(v.exp_gnt));
    chk("launch_avail", 64'(hs.o_data_avail), 64'd1);
    chk("launch_data", 64'(hs.o_t_data), 64'(exp_word));
    chk("launch_busy", 64'(hs.o_busy), 64'd1);
    $display("xfer %0d req=%b gnt=%b word=%h", e, v.req, hs.o_gnt, hs.o_t_data);
    hs.i_req = v.req_after;
    for (int k = 0; k < NREQ; k++) hs.i_req_data[k*DW +: DW] = $urandom;
    repeat (v.rise) begin
      step();
      chk("hold_avail", 64'(hs.o_data_avail), 64'd1);
      chk("hold_data", 64'(hs.o_t_data), 64'(exp_word));
    end
    hs.i_t_rdy = 1'b1;
    step();
    chk("rdy_avail_low", 64'(hs.o_data_avail), 64'd0);
    chk("wait_gnt", 64'(hs.o_gnt), 64'(v.exp_gnt));
    repeat (v.fall) begin
      step();
      chk("wait_avail", 64'(hs.o_data_avail), 64'd0);
      chk("wait_data", 64'(hs.o_t_data), 64'(exp_word));
    end
    hs.i_t_rdy = 1'b0;
    step();
    chk("done_pulse", 64'(hs.o_done), 64'(v.exp_gnt));
    chk("done_busy", 64'(hs.o_busy), 64'd1);
    step();
    chk("arb_done", 64'(hs.o_done), 64'd0);
    chk("arb_gnt", 64'(hs.o_gnt), 64'd0);
    chk("arb_data", 64'(hs.o_t_data), 64'd0);
    chk("arb_busy", 64'(hs.o_busy), 64'd0);
  endtask

  // Scoreboard: each done pulse must match the oldest expected transfer.
  always @(negedge tclk) begin
    if (trst_n) begin
      if (|hs.o_done) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_done actual=%b required=none", hs.o_done);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("sb_done", 64'(hs.o_done), 64'(e.gnt));
          chk("sb_data", 64'(hs.o_t_data), 64'(e.data));
        end
      end
      if (|hs.o_abort && !abort_ok) begin
        total++;
        bad++;
        $display("FAIL unexpected_abort actual=%b required=0", hs.o_abort);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    trst_n        = 1'b0;
    hs.i_req      = '0;
    hs.i_req_data = '0;
    hs.i_t_rdy    = 1'b0;

    vecs[0]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 3, 4, 0};
    vecs[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b0001, 1, 1, 0};
    vecs[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b0010, 0, 0, 0};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 4'b0100, 2, 1, 0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1111, 4'b1000, 1, 3, 0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 0, 2, 0};
    vecs[6]  = '{1'b1, 4'b0100, 4'b0101, 4'b0100, 2, 2, 0};
    vecs[7]  = '{1'b0, 4'b0101, 4'b0101, 4'b0001, 1, 1, 0};
    vecs[8]  = '{1'b0, 4'b0101, 4'b0101, 4'b0100, 1, 1, 0};
    vecs[9]  = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 0, 0, 0};
    vecs[10] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1, 0, 0};
    vecs[11] = '{1'b0, 4'b1001, 4'b0000, 4'b1000, 2, 2, 0};
    vecs[12] = '{1'b0, 4'b0110, 4'b0110, 4'b0010, 1, 1, 0};
    vecs[13] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 0, 1, 0};
    vecs[14] = '{1'b0, 4'b0111, 4'b0000, 4'b0001, 1, 1, 0};
    vecs[15] = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 1, 1, 3};

    for (int e = 0; e < 16; e++) xfer(vecs[e], e);

    // Reset while in WAIT_DONE: outputs clear at once, no done, ptr restarts.
    do_reset();
    load_words(20);
    hs.i_req = 4'b0100;
    step();
    chk("rmid_gnt", 64'(hs.o_gnt), 64'b0100);
    hs.i_t_rdy = 1'b1;
    step();
    chk("rmid_wait_avail", 64'(hs.o_data_avail), 64'd0);
    chk("rmid_wait_busy", 64'(hs.o_busy), 64'd1);
    #2;
    trst_n = 1'b0;
    #1;
    chk_idle("rmid_async");
    hs.i_t_rdy = 1'b0;
    hs.i_req   = '0;
    step();
    step();
    trst_n = 1'b1;
    $display("xfer reset-in-flight abandoned");
    v = '{1'b0, 4'b0101, 4'b0101, 4'b0001, 1, 1, 0};
    xfer(v, 21);

`ifdef HS_ARB_TIMEOUT_EN
    // Ready never rises: abort 15 cycles after LAUNCH entry, ptr advances.
    do_reset();
    load_words(30);
    abort_ok = 1;
    hs.i_req = 4'b0010;
    step();
    chk("to_gnt", 64'(hs.o_gnt), 64'b0010);
    hs.i_req = '0;
    repeat (14) begin
      step();
      chk("to_pre_abort", 64'(hs.o_abort), 64'd0);
      chk("to_pre_avail", 64'(hs.o_data_avail), 64'd1);
    end
    step();
    chk("to_abort", 64'(hs.o_abort), 64'b0010);
    chk("to_avail", 64'(hs.o_data_avail), 64'd0);
    chk("to_gnt_clr", 64'(hs.o_gnt), 64'd0);
    chk("to_busy", 64'(hs.o_busy), 64'd0);
    chk("to_no_done", 64'(hs.o_done), 64'd0);
    step();
    chk("to_abort_pulse", 64'(hs.o_abort), 64'd0);
    abort_ok = 0;
    $display("xfer timeout abort on requester 1");
    v = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 1, 1, 0};
    xfer(v, 31);
`endif

    step();
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
